// File: rtl/alu_pkg.sv
// Shared types for the serial ALU: control bundle and FSM state encoding.
package alu_pkg;

    typedef struct packed {
        logic ci;
        logic nb;
        logic ic;
        logic na;
        logic xo;
        logic no;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } alu_state_t;

endpackage

// File: rtl/alu_serial_if.sv
// Operand/result handshake bundle for alu_serial. ALU_OVF_EN adds the vf flag.
interface alu_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             nb;
    logic             ic;
    logic             na;
    logic             xo;
    logic             no;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             co;
    logic             zf;
    logic             nf;
`ifdef ALU_OVF_EN
    logic             vf;
`endif

    modport master (
        output in_valid, a, b, ci, nb, ic, na, xo, no, out_ready,
        input  in_ready, out_valid, out, co, zf, nf
`ifdef ALU_OVF_EN
        , input vf
`endif
    );

    modport slave (
        input  in_valid, a, b, ci, nb, ic, na, xo, no, out_ready,
        output in_ready, out_valid, out, co, zf, nf
`ifdef ALU_OVF_EN
        , output vf
`endif
    );
endinterface

// File: rtl/alu_slice.sv
// Combinational CHUNK-bit ALU slice with ripple carry; ALU_OVF_EN exposes the
// carry into the slice's top bit for overflow detection.
module alu_slice
    import alu_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    input  alu_ctrl_t        ctrl,
    output logic [CHUNK-1:0] res,
    output logic             carry_out
`ifdef ALU_OVF_EN
    , output logic           carry_top
`endif
);

    always_comb begin
        logic c, x, y, k;
        c   = carry_in;
        x   = 1'b0;
        y   = 1'b0;
        k   = 1'b0;
        res = '0;
`ifdef ALU_OVF_EN
        carry_top = 1'b0;
`endif
        for (int unsigned i = 0; i < CHUNK; i++) begin
            x      = a[i] ^ ctrl.na;
            y      = b[i] ^ ctrl.nb;
            // ic masks every carry, including the one entering from the previous slice
            k      = c & ~ctrl.ic;
            res[i] = ((x ^ y ^ k) | (x & y & ctrl.xo)) ^ ctrl.no;
`ifdef ALU_OVF_EN
            if (i == CHUNK - 1) carry_top = c;
`endif
            c      = (x & y) | ((x ^ y) & k);
        end
        carry_out = c;
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: WIDTH-bit operands processed CHUNK bits per clock with a
// registered carry between slices. ALU_OVF_EN enables the signed-overflow flag.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_serial_if.slave   bus
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("alu_serial: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    alu_state_t       r_state;
    logic [WIDTH-1:0] r_a, r_b, r_out;
    alu_ctrl_t        r_ctrl;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic             r_out_valid, r_co, r_zf, r_nf;

    alu_ctrl_t        w_ctrl_in;
    logic             w_accept;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_res;
    logic             w_cout;
    logic [WIDTH-1:0] w_next_out;

    assign w_ctrl_in = '{ci: bus.ci, nb: bus.nb, ic: bus.ic,
                         na: bus.na, xo: bus.xo, no: bus.no};
    assign bus.in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_base       = 32'(r_idx) * CHUNK;

`ifdef ALU_OVF_EN
    logic w_ctop;
    logic r_vf;
    assign bus.vf = r_vf;
`endif

    alu_slice #(.CHUNK(CHUNK)) u_slice (
        .a         (r_a[w_base +: CHUNK]),
        .b         (r_b[w_base +: CHUNK]),
        .carry_in  (r_carry),
        .ctrl      (r_ctrl),
        .res       (w_res),
        .carry_out (w_cout)
`ifdef ALU_OVF_EN
        , .carry_top (w_ctop)
`endif
    );

    always_comb begin
        w_next_out = r_out;
        w_next_out[w_base +: CHUNK] = w_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_co        <= 1'b0;
            r_zf        <= 1'b0;
            r_nf        <= 1'b0;
`ifdef ALU_OVF_EN
            r_vf        <= 1'b0;
`endif
        end else begin
            // Accept is shared by IDLE and the DONE->RUN back-to-back path
            if (w_accept) begin
                r_a         <= bus.a;
                r_b         <= bus.b;
                r_ctrl      <= w_ctrl_in;
                r_carry     <= bus.ci;
                r_idx       <= '0;
                r_out_valid <= 1'b0;
                r_state     <= RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        r_out   <= w_next_out;
                        r_carry <= w_cout;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
                            r_co        <= w_cout;
                            r_zf        <= (w_next_out == '0);
                            r_nf        <= w_next_out[WIDTH-1];
`ifdef ALU_OVF_EN
                            r_vf        <= w_ctop ^ w_cout;
`endif
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                    IDLE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.co        = r_co;
    assign bus.zf        = r_zf;
    assign bus.nf        = r_nf;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=16, CHUNK=4): directed vector table,
// handshake/reset corner sequences and randomized ops against a behavioural model.
module tb_alu_serial;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_serial_if #(.WIDTH(W)) bus ();

    alu_serial #(.WIDTH(W), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  ctrl;   // {ci,nb,ic,na,xo,no}
        logic [15:0] exp_out;
        logic        exp_co;
        logic        exp_zf;
        logic        exp_nf;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: word-level add with explicit carry vector, or bitwise when carries are inhibited.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                         output logic [15:0] o, output logic co, output logic zf,
                         output logic nf, output logic vf);
        logic ci, nb, ic, na, xo, no;
        logic [15:0] x, y, z, cv;
        logic [16:0] s;
        {ci, nb, ic, na, xo, no} = c;
        x = na ? ~a : a;
        y = nb ? ~b : b;
        if (ic) begin
            z  = xo ? (x | y) : (x ^ y);
            cv = {x[14:0] & y[14:0], 1'b0};
            co = x[15] & y[15];
        end else begin
            s  = {1'b0, x} + {1'b0, y} + 17'(ci);
            z  = s[15:0] | (xo ? (x & y) : 16'h0000);
            cv = s[15:0] ^ x ^ y;
            co = s[16];
        end
        vf = cv[15] ^ co;
        o  = no ? ~z : z;
        zf = (o == 16'h0000);
        nf = o[15];
    endtask

    task automatic drive_in(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        bus.a = a;
        bus.b = b;
        {bus.ci, bus.nb, bus.ic, bus.na, bus.xo, bus.no} = c;
        bus.in_valid = 1'b1;
    endtask

    // Counts edges from the accept edge until out_valid, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                          output logic [15:0] o, output logic co, output logic zf,
                          output logic nf, output logic vf, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        drive_in(a, b, c);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(lat);
        o  = bus.out;
        co = bus.co;
        zf = bus.zf;
        nf = bus.nf;
`ifdef ALU_OVF_EN
        vf = bus.vf;
`else
        vf = 1'b0;
`endif
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] o, ea, eb, eo, hold_out;
        logic [5:0]  ec;
        logic        co, zf, nf, vf, eco, ezf, enf, evf;
        int          lat;

        vt[0] = '{16'h1234, 16'h0FFF, 6'b000000, 16'h2233, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 6'b000000, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[2] = '{16'h00FF, 16'h0F0F, 6'b001000, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h00F0, 16'h0F00, 6'b001010, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h0005, 16'h0003, 6'b000101, 16'h0002, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h0003, 16'h0005, 6'b000101, 16'hFFFE, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(16'h0, 16'h0, 6'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_flags", 32'({bus.co, bus.zf, bus.nf}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].ctrl, o, co, zf, nf, vf, lat);
            check($sformatf("vec%0d_out", i), 32'(o), 32'(vt[i].exp_out));
            check($sformatf("vec%0d_co", i), 32'(co), 32'(vt[i].exp_co));
            check($sformatf("vec%0d_zf", i), 32'(zf), 32'(vt[i].exp_zf));
            check($sformatf("vec%0d_nf", i), 32'(nf), 32'(vt[i].exp_nf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // Back-pressure in DONE, then same-cycle accept of the next op.
        @(negedge clk);
        drive_in(16'h1234, 16'h0FFF, 6'b000000);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd4);
        hold_out = bus.out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_stable", 32'({bus.out, bus.co, bus.zf, bus.nf}),
                  32'({16'h2233, 3'b000}));
            check("bp_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        check("bp_hold_first", 32'(hold_out), 32'h2233);
        drive_in(16'h0003, 16'h0005, 6'b000101);
        bus.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
        wait_result(lat);
        check("b2b_latency", 32'(lat), 32'd4);
        check("b2b_out", 32'({bus.out, bus.co, bus.nf}), 32'({16'hFFFE, 1'b1, 1'b1}));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Asynchronous reset at idx=2 discards the op.
        @(negedge clk);
        drive_in(16'h1111, 16'h2222, 6'b000000);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_partial", 32'(bus.out[7:0]), 32'h33);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out", 32'(bus.out), 32'd0);
        check("midrst_flags", 32'({bus.co, bus.zf, bus.nf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'hFFFF, 16'h0001, 6'b000000, o, co, zf, nf, vf, lat);
        check("post_rst_out", 32'({o, co, zf, nf}), 32'({16'h0000, 3'b110}));
        check("post_rst_latency", 32'(lat), 32'd4);

`ifdef ALU_OVF_EN
        run_op(16'h7FFF, 16'h0001, 6'b000000, o, co, zf, nf, vf, lat);
        check("ovf_out", 32'(o), 32'h8000);
        check("ovf_vf_nf", 32'({vf, nf, co}), 32'({1'b1, 1'b1, 1'b0}));
`endif

        for (int i = 0; i < 40; i++) begin
            ea = 16'($urandom);
            eb = 16'($urandom);
            ec = 6'($urandom_range(0, 63));
            if (i < 4) ea = 16'hFFFF;
            model(ea, eb, ec, eo, eco, ezf, enf, evf);
            run_op(ea, eb, ec, o, co, zf, nf, vf, lat);
            check($sformatf("rnd%0d_out", i), 32'(o), 32'(eo));
            check($sformatf("rnd%0d_co", i), 32'(co), 32'(eco));
            check($sformatf("rnd%0d_zf_nf", i), 32'({zf, nf}), 32'({ezf, enf}));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
`ifdef ALU_OVF_EN
            check($sformatf("rnd%0d_vf", i), 32'(vf), 32'(evf));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
